// File: rtl/state_timer_sel.sv
// Per-state duration timer: maps the controller state onto a duration channel, loads it
// into a down-counter advanced by the prescaler tick and pulses done at expiry.
module state_timer_sel #(
  parameter int unsigned WIDTH      = 19,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned STATE_W    = 4,
  parameter int unsigned BASE_STATE = 2,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [STATE_W-1:0]      present_state,
  input  logic [NUM_CH*WIDTH-1:0] t_in,
  input  logic                    tick,
  input  logic                    hold,
  input  logic                    restart,
  output logic [WIDTH-1:0]        tout,
  output logic [CH_W-1:0]         ch_idx,
  output logic                    ch_valid,
  output logic                    running,
  output logic                    done
);

  localparam logic [STATE_W-1:0] BaseCode  = STATE_W'(BASE_STATE);
  // One extra bit so NUM_CH == 2**STATE_W still compares correctly.
  localparam logic [STATE_W:0]   NumChExt  = (STATE_W + 1)'(NUM_CH);
  localparam logic [WIDTH-1:0]   OneCount  = WIDTH'(1);

  logic [WIDTH-1:0]   tout_q, tout_d;
  logic [CH_W-1:0]    ch_idx_q, ch_idx_d;
  logic               ch_valid_q, ch_valid_d;
  logic               running_q, running_d;
  logic               done_q, done_d;
  logic [STATE_W-1:0] prev_state_q;
  logic               first_q;

  logic [STATE_W-1:0] sel;
  logic               valid;
  logic [WIDTH-1:0]   dur;
  logic               load;
  logic               count;

  // Decode
  assign sel   = present_state - BaseCode;
  assign valid = (present_state >= BaseCode) && ({1'b0, sel} < NumChExt);

  always_comb begin
    dur = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == STATE_W'(i)) begin
        dur = t_in[i*WIDTH +: WIDTH];
      end
    end
  end

  assign load  = valid && ((present_state != prev_state_q) || restart || first_q);
  assign count = running_q && tick && !hold;

  // Next state: invalid > load > count > idle
  always_comb begin
    tout_d     = tout_q;
    ch_idx_d   = ch_idx_q;
    ch_valid_d = ch_valid_q;
    running_d  = running_q;
    done_d     = 1'b0;
    if (!valid) begin
      tout_d     = '0;
      ch_idx_d   = '0;
      ch_valid_d = 1'b0;
      running_d  = 1'b0;
    end else if (load) begin
      tout_d     = dur;
      ch_idx_d   = CH_W'(sel);
      ch_valid_d = 1'b1;
      running_d  = (dur != '0);
      done_d     = (dur == '0);
    end else if (count) begin
      tout_d = tout_q - OneCount;
      if (tout_q == OneCount) begin
        running_d = 1'b0;
        done_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tout_q       <= '0;
      ch_idx_q     <= '0;
      ch_valid_q   <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      prev_state_q <= '0;
      first_q      <= 1'b1;
    end else begin
      tout_q       <= tout_d;
      ch_idx_q     <= ch_idx_d;
      ch_valid_q   <= ch_valid_d;
      running_q    <= running_d;
      done_q       <= done_d;
      prev_state_q <= present_state;
      first_q      <= 1'b0;
    end
  end

  assign tout     = tout_q;
  assign ch_idx   = ch_idx_q;
  assign ch_valid = ch_valid_q;
  assign running  = running_q;
  assign done     = done_q;

endmodule

// File: tb/tb_state_timer_sel.sv
// Bench for state_timer_sel: directed scenarios plus randomized traffic, all compared
// against a behavioural duration-timer model.
module tb_state_timer_sel;

  localparam int WIDTH      = 19;
  localparam int NUM_CH     = 4;
  localparam int STATE_W    = 4;
  localparam int BASE_STATE = 2;
  localparam int CH_W       = 2;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [STATE_W-1:0]      present_state = '0;
  logic [NUM_CH*WIDTH-1:0] t_in = '0;
  logic                    tick = 1'b0;
  logic                    hold = 1'b0;
  logic                    restart = 1'b0;
  logic [WIDTH-1:0]        tout;
  logic [CH_W-1:0]         ch_idx;
  logic                    ch_valid;
  logic                    running;
  logic                    done;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  int durs [NUM_CH];
  int m_tout, m_idx, m_prev;
  bit m_valid, m_run, m_done, m_first;

  state_timer_sel #(
    .WIDTH(WIDTH), .NUM_CH(NUM_CH), .STATE_W(STATE_W), .BASE_STATE(BASE_STATE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .present_state(present_state), .t_in(t_in),
    .tick(tick), .hold(hold), .restart(restart), .tout(tout), .ch_idx(ch_idx),
    .ch_valid(ch_valid), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  task automatic set_durs();
    for (int i = 0; i < NUM_CH; i++) t_in[i*WIDTH +: WIDTH] = WIDTH'(durs[i]);
  endtask

  task automatic model_reset();
    m_tout = 0; m_idx = 0; m_valid = 0; m_run = 0; m_done = 0; m_prev = 0; m_first = 1;
  endtask

  // Timer behaviour of one clock edge, from the present inputs.
  task automatic model_edge();
    int code, c;
    code = int'(present_state);
    c    = code - BASE_STATE;
    if (code < BASE_STATE || c >= NUM_CH) begin
      m_tout = 0; m_idx = 0; m_valid = 0; m_run = 0; m_done = 0;
    end else if (code != m_prev || restart || m_first) begin
      m_tout = durs[c]; m_idx = c; m_valid = 1;
      m_run = (durs[c] != 0); m_done = (durs[c] == 0);
    end else if (m_run && tick && !hold) begin
      m_tout = m_tout - 1;
      m_done = (m_tout == 0);
      if (m_tout == 0) m_run = 0;
    end else begin
      m_done = 0;
    end
    m_prev  = code;
    m_first = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    present_state = 4'b0000;
    #12;
    model_reset();
    vectors++;
    if ({tout, ch_idx, ch_valid, running, done} !== '0)
      begin errors++; $display("FAIL reset: got tout=%0d idx=%0d v=%0b r=%0b d=%0b want all 0",
                               tout, ch_idx, ch_valid, running, done); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    durs = '{3, 5, 10, 0};
    set_durs();
    present_state = 4'b0010;
    tick = 1'b1;
    for (int n = 0; n < 6; n++) begin
      step();
      vectors++;
      if (tout !== WIDTH'(m_tout) || ch_idx !== CH_W'(m_idx) || ch_valid !== m_valid ||
          running !== m_run || done !== m_done)
        begin errors++; $display("FAIL basic[%0d]: got %0d/%0d/%0b/%0b/%0b want %0d/%0d/%0b/%0b/%0b",
          n, tout, ch_idx, ch_valid, running, done, m_tout, m_idx, m_valid, m_run, m_done); end
    end
    tick = 1'b0;
  endtask

  task automatic test_hold();
    int ticks;
    ticks = 0;
    present_state = 4'b0011;
    for (int n = 0; n < 28; n++) begin
      tick = (n % 4 == 3);
      if (tick) ticks++;
      hold = tick && (ticks == 2);
      step();
      vectors++;
      if (tout !== WIDTH'(m_tout) || ch_idx !== CH_W'(m_idx) || ch_valid !== m_valid ||
          running !== m_run || done !== m_done)
        begin errors++; $display("FAIL hold[%0d]: got %0d/%0d/%0b/%0b/%0b want %0d/%0d/%0b/%0b/%0b",
          n, tout, ch_idx, ch_valid, running, done, m_tout, m_idx, m_valid, m_run, m_done); end
    end
    tick = 1'b0;
    hold = 1'b0;
  endtask

  task automatic test_switch();
    durs[0] = 9;
    set_durs();
    present_state = 4'b0010;
    tick = 1'b1;
    for (int n = 0; n < 3; n++) step();
    // tout is now 7 on channel 0
    present_state = 4'b0100;
    step();
    vectors++;
    if (tout !== WIDTH'(m_tout) || ch_idx !== CH_W'(m_idx) || done !== 1'b0 || m_tout != 10)
      begin errors++; $display("FAIL switch: got tout=%0d idx=%0d done=%0b want tout=%0d idx=%0d done=0",
                               tout, ch_idx, done, m_tout, m_idx); end
    tick = 1'b0;
  endtask

  task automatic test_abandon();
    tick = 1'b1;
    step();
    present_state = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      step();
      vectors++;
      if (tout !== '0 || ch_valid !== 1'b0 || running !== 1'b0 || done !== 1'b0)
        begin errors++; $display("FAIL abandon[%0d]: got %0d/%0b/%0b/%0b want 0/0/0/0",
                                 n, tout, ch_valid, running, done); end
    end
    present_state = 4'b0010;
    step();
    vectors++;
    if (tout !== WIDTH'(m_tout) || ch_idx !== CH_W'(m_idx) || running !== m_run)
      begin errors++; $display("FAIL reenter: got tout=%0d idx=%0d r=%0b want %0d/%0d/%0b",
                               tout, ch_idx, running, m_tout, m_idx, m_run); end
    tick = 1'b0;
  endtask

  task automatic test_zero();
    present_state = 4'b0101;
    for (int n = 0; n < 6; n++) begin
      restart = (n == 3);
      step();
      vectors++;
      if (tout !== WIDTH'(m_tout) || ch_idx !== CH_W'(m_idx) || ch_valid !== m_valid ||
          running !== m_run || done !== m_done)
        begin errors++; $display("FAIL zero[%0d]: got %0d/%0d/%0b/%0b/%0b want %0d/%0d/%0b/%0b/%0b",
          n, tout, ch_idx, ch_valid, running, done, m_tout, m_idx, m_valid, m_run, m_done); end
    end
    restart = 1'b0;
  endtask

  task automatic test_async_reset();
    present_state = 4'b0010;
    tick = 1'b1;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if ({tout, ch_idx, ch_valid, running, done} !== '0)
      begin errors++; $display("FAIL async_reset: got tout=%0d idx=%0d v=%0b r=%0b d=%0b want all 0",
                               tout, ch_idx, ch_valid, running, done); end
    #2;
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      vectors++;
      if (tout !== WIDTH'(m_tout) || ch_idx !== CH_W'(m_idx) || ch_valid !== m_valid ||
          running !== m_run || done !== m_done)
        begin errors++; $display("FAIL post_reset[%0d]: got %0d/%0d/%0b/%0b/%0b want %0d/%0d/%0b/%0b/%0b",
          n, tout, ch_idx, ch_valid, running, done, m_tout, m_idx, m_valid, m_run, m_done); end
    end
    tick = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 9) == 0) present_state = STATE_W'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) begin
        durs[$urandom_range(0, NUM_CH - 1)] = $urandom_range(0, 6);
        set_durs();
      end
      tick    = ($urandom_range(0, 1) == 1);
      hold    = ($urandom_range(0, 4) == 0);
      restart = ($urandom_range(0, 19) == 0);
      step();
      vectors++;
      if (tout !== WIDTH'(m_tout) || ch_idx !== CH_W'(m_idx) || ch_valid !== m_valid ||
          running !== m_run || done !== m_done)
        begin errors++; $display("FAIL random[%0d]: got %0d/%0d/%0b/%0b/%0b want %0d/%0d/%0b/%0b/%0b",
          n, tout, ch_idx, ch_valid, running, done, m_tout, m_idx, m_valid, m_run, m_done); end
    end
    tick = 1'b0; hold = 1'b0; restart = 1'b0;
  endtask

  initial begin
    durs = '{0, 0, 0, 0};
    model_reset();
    test_reset();
    test_basic();
    test_hold();
    test_switch();
    test_abandon();
    durs[3] = 0;
    set_durs();
    test_zero();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/state_timer_sel.md
Name: state_timer_sel

Overview:
- Parametrised successor to the train controller's per-state timer selector.
- Maps the controller FSM's present_state onto one of NUM_CH duration channels and latches that channel's duration into a down-counter.
- Counts the duration down on a prescaler tick and emits a single-cycle done pulse at expiry, which the FSM uses to advance state.
- Output is fully registered: one clock, no clock-level gating.

Parameters:
- WIDTH, 19: bit width of each duration channel and of the counter.
- NUM_CH, 4: number of duration channels (1..16).
- STATE_W, 4: width of the present_state code.
- BASE_STATE, 2: state code mapped to channel 0. Code BASE_STATE+i maps to channel i for i < NUM_CH; all other codes are idle codes.
- CH_W (localparam), max(1, clog2(NUM_CH)): channel index width.

Ports:
- clk, input, 1: system clock; all state changes on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- present_state, input, STATE_W: controller FSM state code.
- t_in, input, NUM_CH*WIDTH: packed durations; channel i occupies bits [i*WIDTH +: WIDTH].
- tick, input, 1: single-cycle count enable from the prescaler.
- hold, input, 1: freezes the countdown while high.
- restart, input, 1: single-cycle pulse that reloads the current channel without a state change.
- tout, output, WIDTH: remaining count (registered).
- ch_idx, output, CH_W: active channel index (registered); 0 when idle.
- ch_valid, output, 1: present_state is a mapped code (registered).
- running, output, 1: countdown in progress.
- done, output, 1: one-cycle expiry pulse.

Behaviour:
- Reset (rst_n low, asynchronous):
  - tout=0, ch_idx=0, ch_valid=0, running=0, done=0.
  - prev_state=0; internal first flag set to 1.
  - Deassertion takes effect at the next clk edge.
- Decode (combinational):
  - sel = present_state - BASE_STATE.
  - valid = present_state >= BASE_STATE && sel < NUM_CH.
  - dur = t_in slice for sel.
- Load condition:
  - load = valid && (present_state != prev_state || restart || first).
  - first clears on the first edge after reset.
  - prev_state <= present_state every edge.
- Priority per edge, highest first: invalid state, load, count, idle.
- Invalid state (valid=0):
  - tout<=0, running<=0, done<=0, ch_valid<=0, ch_idx<=0.
  - A countdown in progress is abandoned; no done pulse is issued.
- Load:
  - tout<=dur, ch_idx<=sel, ch_valid<=1.
  - If dur!=0: running<=1, done<=0.
  - If dur==0: running<=0, done<=1 (done visible the cycle after the load edge).
  - Load overrides a coincident tick.
  - A state change to another valid code mid-count reloads immediately; the old channel produces no done.
- Count (running && tick && !hold && !load):
  - tout<=tout-1.
  - If tout==1: running<=0 and done<=1 for exactly one cycle.
- Otherwise:
  - done<=0; tout holds.
  - After expiry tout stays 0; further ticks are ignored until the next load.
  - hold with tick means no decrement. hold does not block a load.
- t_in changes after load do not affect the count in progress.
- Latency: load→tout valid 1 cycle. A duration N expires on the Nth accepted tick; done is high the cycle after that edge.
- No wrap-around: tout never decrements below 0.
- restart while idle (invalid state) is ignored.

Test Plan:
- Reset, then present_state=4'b0010, t_in ch0=3, tick every cycle → next edge tout=3, running=1; tout 2,1,0 on the following edges; done=1 for one cycle coincident with tout=0, then running=0.
- present_state=4'b0011, ch1=5, tick every 4th cycle, hold high across the 2nd tick → decrements only on accepted ticks; done after the 5th accepted tick; tout frozen during hold.
- Mid-count (tout=7 on ch0), present_state→4'b0100 (ch2=10) with coincident tick → tout=10, ch_idx=2, no done pulse.
- present_state→4'b0000 while running → tout=0, ch_valid=0, running=0, done never asserted; return to 4'b0010 → reload from ch0.
- ch3=0, present_state=4'b0101 → running=0, done=1 for exactly one cycle after the load; restart pulse → done pulses again.
- rst_n pulsed low mid-count, asynchronously between edges → outputs 0 immediately; after release with present_state unchanged=4'b0010, the first flag forces a reload of ch0.
